// File: rtl/dc_fu_pkg.sv
// Shared pixel types and the RGB565 -> RGB888 expansion used by the fetching-unit pixel FIFO.
package dc_fu_pkg;

  localparam int DC_FU_PIX_W_565 = 16;
  localparam int DC_FU_PIX_W_888 = 24;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // MSB replication so full-scale 565 maps to full-scale 888.
  function automatic rgb888_t rgb565_to_888(input rgb565_t p);
    rgb888_t q;
    q.r = {p.r, p.r[4:2]};
    q.g = {p.g, p.g[5:4]};
    q.b = {p.b, p.b[4:2]};
    return q;
  endfunction

endpackage

// File: rtl/dc_fu_pixel_fifo_mem.sv
// Simple dual-port pixel storage: synchronous write, combinational read.
module dc_fu_pixel_fifo_mem
  import dc_fu_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  rgb565_t       wdata,
  input  logic [AW-1:0] raddr,
  output rgb565_t       rdata
);

  rgb565_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dc_fu_pixel_fifo.sv
// FWFT pixel FIFO between the AXI R channel and the scaler, with line markers.
// Optional feature macro: DC_FU_PIXEL_FIFO_RGB888_EN (24-bit RGB888 output instead of RGB565).
module dc_fu_pixel_fifo
  import dc_fu_pkg::*;
#(
  parameter int DEPTH        = 32,
  parameter int LINE_WIDTH_W = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       flush,
  input  logic [LINE_WIDTH_W-1:0]    line_width,
  input  logic [15:0]                axi_rdata,
  input  logic                       axi_rvalid,
  input  logic                       axi_rlast,
  output logic                       axi_rready,
`ifdef DC_FU_PIXEL_FIFO_RGB888_EN
  output logic [DC_FU_PIX_W_888-1:0] pix_data,
`else
  output logic [DC_FU_PIX_W_565-1:0] pix_data,
`endif
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic                       pix_sol,
  output logic                       pix_eol,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [LW-1:0]           level, mem_count;
  logic                    ready_en, out_valid;
  rgb565_t                 out_data, mem_rdata;
  logic [LINE_WIDTH_W-1:0] pix_count, last_idx;
  logic                    wr_en, consume, mem_empty, bypass, mem_we, refill, at_eol;
  logic                    unused_rlast;

  assign unused_rlast = axi_rlast;

  // level counts the output register too, so the memory never holds more than DEPTH-1.
  assign axi_rready = ready_en && en && !flush && (level < LW'(DEPTH));

  always_comb begin
    wr_en     = axi_rvalid && axi_rready;
    consume   = en && !flush && out_valid && pix_ready;
    mem_count = level - LW'(out_valid);
    mem_empty = (mem_count == '0);
    bypass    = wr_en && (!out_valid || (consume && mem_empty));
    mem_we    = wr_en && !bypass;
    refill    = consume && !mem_empty;
    last_idx  = line_width - LINE_WIDTH_W'(1);
    at_eol    = (line_width != '0) && (pix_count == last_idx);
  end

  dc_fu_pixel_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (rgb565_t'(axi_rdata)),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      pix_count <= '0;
    end else begin
      ready_en <= 1'b1;
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        level     <= '0;
        out_valid <= 1'b0;
        pix_count <= '0;
      end else if (en) begin
        if (mem_we) wr_ptr <= wr_ptr + AW'(1);
        if (refill) rd_ptr <= rd_ptr + AW'(1);
        level <= level + LW'(wr_en) - LW'(consume);
        // Refill and bypass are exclusive: bypass on consume needs an empty memory.
        if (refill) begin
          out_data  <= mem_rdata;
          out_valid <= 1'b1;
        end else if (bypass) begin
          out_data  <= rgb565_t'(axi_rdata);
          out_valid <= 1'b1;
        end else if (consume) begin
          out_valid <= 1'b0;
        end
        if (consume) pix_count <= at_eol ? '0 : pix_count + LINE_WIDTH_W'(1);
      end
    end
  end

  assign pix_valid  = out_valid;
  assign pix_sol    = out_valid && (pix_count == '0);
  assign pix_eol    = out_valid && at_eol;
  assign fifo_level = level;

`ifdef DC_FU_PIXEL_FIFO_RGB888_EN
  assign pix_data = rgb565_to_888(out_data);
`else
  assign pix_data = out_data;
`endif

endmodule

// File: tb/tb_dc_fu_pixel_fifo.sv
// Self-checking bench for dc_fu_pixel_fifo: queue-based scoreboard plus a table of colour vectors.
module tb_dc_fu_pixel_fifo;

  localparam int DEPTH = 32;
  localparam int LWW   = 12;
  localparam int LVW   = $clog2(DEPTH) + 1;
`ifdef DC_FU_PIXEL_FIFO_RGB888_EN
  localparam int PW = 24;
`else
  localparam int PW = 16;
`endif

  logic           clk = 1'b0;
  logic           rst, en, flush;
  logic [LWW-1:0] line_width;
  logic [15:0]    axi_rdata;
  logic           axi_rvalid, axi_rlast, axi_rready;
  logic [PW-1:0]  pix_data;
  logic           pix_valid, pix_ready, pix_sol, pix_eol;
  logic [LVW-1:0] fifo_level;

  dc_fu_pixel_fifo #(.DEPTH(DEPTH), .LINE_WIDTH_W(LWW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .flush      (flush),
    .line_width (line_width),
    .axi_rdata  (axi_rdata),
    .axi_rvalid (axi_rvalid),
    .axi_rlast  (axi_rlast),
    .axi_rready (axi_rready),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_sol    (pix_sol),
    .pix_eol    (pix_eol),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int             n_checks = 0;
  int             n_fail   = 0;
  logic [15:0]    exp_q[$];
  logic [LWW-1:0] exp_cnt;
  logic           rdy_ok;
  logic           last_valid, last_sol, last_eol;
  logic [PW-1:0]  last_data;

  typedef struct {
    logic [15:0] din;
    logic [23:0] exp888;
  } rgb_vec_t;

  function automatic logic [PW-1:0] expect_pix(input logic [15:0] d);
`ifdef DC_FU_PIXEL_FIFO_RGB888_EN
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
`else
    return d;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic checkState();
    logic v;
    v = (exp_q.size() > 0);
    last_valid = pix_valid;
    last_sol   = pix_sol;
    last_eol   = pix_eol;
    last_data  = pix_data;
    checkOutput("pix_valid", 32'(pix_valid), 32'(v));
    checkOutput("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
    checkOutput("pix_sol", 32'(pix_sol), 32'(v && exp_cnt == '0));
    checkOutput("pix_eol", 32'(pix_eol),
                32'(v && line_width != '0 && exp_cnt == line_width - LWW'(1)));
    if (v) checkOutput("pix_data", 32'(pix_data), 32'(expect_pix(exp_q[0])));
  endtask

  // One clock cycle: check outputs at the falling edge, drive inputs, update the model at the rising edge.
  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic r,
                               input logic e, input logic f, output logic acc);
    logic m_rdy, cons;
    logic [15:0] popped;
    @(negedge clk);
    checkState();
    axi_rvalid = v;
    axi_rdata  = d;
    pix_ready  = r;
    en         = e;
    flush      = f;
    #1;
    m_rdy = rdy_ok && e && !f && (exp_q.size() < DEPTH);
    checkOutput("axi_rready", 32'(axi_rready), 32'(m_rdy));
    acc  = v && m_rdy;
    cons = e && !f && r && (exp_q.size() > 0);
    @(posedge clk);
    if (f) begin
      exp_q.delete();
      exp_cnt = '0;
    end else if (e) begin
      if (cons) begin
        popped  = exp_q.pop_front();
        exp_cnt = (line_width != '0 && exp_cnt == line_width - LWW'(1)) ? '0 : exp_cnt + LWW'(1);
      end
      if (acc) exp_q.push_back(d);
    end
    rdy_ok = 1'b1;
  endtask

  task automatic idleCycles(input int n, input logic r);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0, r, 1'b1, 1'b0, acc);
  endtask

  task automatic pushBeats(input int n, input logic [15:0] base);
    logic acc;
    logic [15:0] d;
    d = base;
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, d, 1'b0, 1'b1, 1'b0, acc);
      d = d + 16'h1;
    end
  endtask

  initial begin
    rgb_vec_t    vecs[6];
    logic        acc;
    logic [15:0] data;
    int          n_acc, n_sol, n_eol;
    logic [23:0] exp_v;

    vecs[0] = '{16'hF81F, 24'hFF00FF};
    vecs[1] = '{16'h07E0, 24'h00FF00};
    vecs[2] = '{16'h0001, 24'h000008};
    vecs[3] = '{16'h8410, 24'h848284};
    vecs[4] = '{16'hFFFF, 24'hFFFFFF};
    vecs[5] = '{16'h0000, 24'h000000};

    rst = 1'b1; en = 1'b0; flush = 1'b0; line_width = 12'd5;
    axi_rdata = '0; axi_rvalid = 1'b0; axi_rlast = 1'b0; pix_ready = 1'b0;
    rdy_ok = 1'b0; exp_cnt = '0;

    // Reset values
    repeat (2) @(negedge clk);
    en = 1'b1;
    #1;
    checkOutput("rst_rready", 32'(axi_rready), 32'd0);
    checkOutput("rst_valid", 32'(pix_valid), 32'd0);
    checkOutput("rst_level", 32'(fifo_level), 32'd0);
    checkOutput("rst_data", 32'(pix_data), 32'd0);
    checkOutput("rst_sol_eol", 32'({pix_sol, pix_eol}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rready_at_release", 32'(axi_rready), 32'd0);
    @(posedge clk);
    rdy_ok = 1'b1;

    $display("[TB] back-to-back beats");
    n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 16'(i + 1), 1'b1, 1'b1, 1'b0, acc);
      if (acc) n_acc++;
    end
    checkOutput("b2b_accepts", 32'(n_acc), 32'd4);
    idleCycles(3, 1'b1);

    $display("[TB] fill to full and drain");
    data = 16'h0100; n_acc = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, data, 1'b0, 1'b1, 1'b0, acc);
      if (acc) begin data++; n_acc++; end
    end
    checkOutput("full_accepts", 32'(n_acc), 32'd32);
    idleCycles(34, 1'b1);

    $display("[TB] line markers");
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, acc);
    line_width = 12'd5;
    pushBeats(12, 16'h0200);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, acc);
      checkOutput("line_sol", 32'(last_sol), 32'(i % 5 == 0));
      checkOutput("line_eol", 32'(last_eol), 32'(i % 5 == 4));
    end

    $display("[TB] flush with concurrent beat");
    pushBeats(9, 16'h0300);
    idleCycles(2, 1'b1);
    applyStimulus(1'b1, 16'hDEAD, 1'b1, 1'b1, 1'b1, acc);
    applyStimulus(1'b1, 16'h0BEE, 1'b0, 1'b1, 1'b0, acc);
    checkOutput("post_flush_valid", 32'(last_valid), 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, acc);
    checkOutput("post_flush_sol", 32'(last_sol), 32'd1);
    checkOutput("post_flush_data", 32'(last_data), 32'(expect_pix(16'h0BEE)));
    idleCycles(1, 1'b1);

    $display("[TB] enable low mid-stream");
    data = 16'h0400;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, data, 1'b1, !(i >= 4 && i < 7), 1'b0, acc);
      if (acc) data++;
    end
    idleCycles(3, 1'b1);

    $display("[TB] colour vectors");
    for (int i = 0; i < 6; i++) begin
`ifdef DC_FU_PIXEL_FIFO_RGB888_EN
      exp_v = vecs[i].exp888;
`else
      exp_v = 24'(vecs[i].din);
`endif
      applyStimulus(1'b1, vecs[i].din, 1'b0, 1'b1, 1'b0, acc);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, acc);
      checkOutput("colour", 32'(last_data), 32'(exp_v));
    end

    $display("[TB] zero line width");
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, acc);
    line_width = 12'd0;
    pushBeats(8, 16'h0500);
    n_sol = 0; n_eol = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, acc);
      if (last_sol) n_sol++;
      if (last_eol) n_eol++;
    end
    checkOutput("lw0_sol_count", 32'(n_sol), 32'd1);
    checkOutput("lw0_eol_count", 32'(n_eol), 32'd0);

    $display("[TB] random traffic");
    line_width = 12'd3;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, acc);
    data = 16'h1000;
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), data, 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 63) == 0), acc);
      if (acc) data++;
    end
    idleCycles(DEPTH + 2, 1'b1);

    $display("[TB] reset mid-stream");
    pushBeats(5, 16'h0600);
    @(negedge clk);
    axi_rvalid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_valid", 32'(pix_valid), 32'd0);
    checkOutput("midrst_level", 32'(fifo_level), 32'd0);
    checkOutput("midrst_rready", 32'(axi_rready), 32'd0);
    checkOutput("midrst_data", 32'(pix_data), 32'd0);
    exp_q.delete();
    exp_cnt = '0;
    rdy_ok  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    rdy_ok = 1'b1;
    data = 16'h0700;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, data, 1'b1, 1'b1, 1'b0, acc);
      if (acc) data++;
    end
    idleCycles(3, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
